// File: rtl/range_stream_framer_pkg.sv
// Shared constants and state encoding for the range-finder serial front end.
package range_pkg;
   localparam int WIDTH     = 10;
   localparam int MAX_WORDS = 255;
   localparam int CNT_W     = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      DRAIN = 3'd2,
      FIN   = 3'd3,
      ERR   = 3'd4
   } framer_state_t;
endpackage

// File: rtl/range_stream_framer_if.sv
// Serial stream in / range-finder drive out; master feeds the stream, slave is the framer.
interface range_stream_framer_if import range_pkg::*; #(
   parameter int WIDTH = range_pkg::WIDTH,
   parameter int CNT_W = range_pkg::CNT_W
);
   logic             ser_in;
   logic             ser_valid;
   logic             frame_start;
   logic             frame_end;
   logic [WIDTH-1:0] data_out;
   logic             go;
   logic             finish;
   logic             word_valid;
   logic [CNT_W-1:0] word_count;
   logic             frame_err;

   modport master (
      output ser_in, ser_valid, frame_start, frame_end,
      input  data_out, go, finish, word_valid, word_count, frame_err
   );

   modport slave (
      input  ser_in, ser_valid, frame_start, frame_end,
      output data_out, go, finish, word_valid, word_count, frame_err
   );
endinterface

// File: rtl/range_stream_framer_bit_deserializer.sv
// MSB-first shift register with bit counter; word/word_done are combinational so the
// framer can capture the completed word on the same edge as the last bit.
module bit_deserializer #(
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             ser_in,
   input  logic             ser_valid,
   output logic [WIDTH-1:0] word,
   output logic             word_done,
   output logic             aligned
);
   localparam int BC_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [BC_W-1:0]  base_cnt;

   // clear restarts the count so a bit arriving with the clear becomes bit 0
   always_comb begin
      base_cnt  = clear ? '0 : bit_cnt_q;
      word      = {shift_q[WIDTH-2:0], ser_in};
      word_done = ser_valid && (base_cnt == BC_W'(WIDTH - 1));
      shift_d   = shift_q;
      bit_cnt_d = base_cnt;
      if (ser_valid) begin
         shift_d   = word;
         bit_cnt_d = word_done ? '0 : base_cnt + 1'b1;
      end
      aligned = (bit_cnt_d == '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end
endmodule

// File: rtl/range_stream_framer.sv
// Frames the serial sample stream into words and sequences go/finish for the range finder.
//   state | meaning
//   IDLE  | waiting for frame_start
//   SHIFT | assembling words
//   DRAIN | last word on data_out for one cycle
//   FIN   | finish pulse to the range finder
//   ERR   | framing error, waiting for next frame_start
module range_stream_framer import range_pkg::*; #(
   parameter int WIDTH     = range_pkg::WIDTH,
   parameter int MAX_WORDS = range_pkg::MAX_WORDS,
   parameter int CNT_W     = range_pkg::CNT_W
) (
   input  logic                 clock,
   input  logic                 reset,
   range_stream_framer_if.slave bus
);
   framer_state_t    state_q, state_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [CNT_W-1:0] word_count_q, word_count_d;
   logic             go_q, go_d;
   logic             finish_q, finish_d;
   logic             word_valid_q, word_valid_d;
   logic             frame_err_q, frame_err_d;

   logic             start_open;
   logic             des_clear;
   logic             des_valid;
   logic [WIDTH-1:0] des_word;
   logic             des_done;
   logic             des_aligned;

   bit_deserializer #(.WIDTH(WIDTH)) u_des (
      .clock     (clock),
      .reset     (reset),
      .clear     (des_clear),
      .ser_in    (bus.ser_in),
      .ser_valid (des_valid),
      .word      (des_word),
      .word_done (des_done),
      .aligned   (des_aligned)
   );

   always_comb begin
      start_open = bus.frame_start && (state_q == IDLE || state_q == FIN || state_q == ERR);
      des_clear  = start_open;
      des_valid  = bus.ser_valid &&
                   ((state_q == SHIFT && !bus.frame_start) ||
                    (start_open && !(state_q == IDLE && bus.frame_end)));

      state_d      = state_q;
      data_out_d   = data_out_q;
      word_count_d = word_count_q;
      go_d         = 1'b0;
      word_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.frame_start) begin
               word_count_d = '0;
               state_d      = bus.frame_end ? ERR : SHIFT;
            end
         end
         SHIFT: begin
            if (bus.frame_start) begin
               state_d = ERR;
            end else begin
               if (des_done) begin
                  if (word_count_q == CNT_W'(MAX_WORDS)) begin
                     state_d = ERR;
                  end else begin
                     data_out_d   = des_word;
                     word_count_d = word_count_q + 1'b1;
                     word_valid_d = 1'b1;
                     go_d         = (word_count_q == '0);
                  end
               end
               // frame_end is judged after this cycle's bit, so it may ride on the last bit
               if (bus.frame_end && state_d == SHIFT)
                  state_d = (des_aligned && word_count_d != '0) ? DRAIN : ERR;
            end
         end
         DRAIN: state_d = bus.frame_start ? ERR : FIN;
         FIN, ERR: begin
            if (bus.frame_start) begin
               word_count_d = '0;
               state_d      = SHIFT;
            end else if (state_q == FIN) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // entering ERR with words delivered must still release the range finder
      finish_d    = (state_d == FIN) ||
                    (state_d == ERR && state_q != ERR && word_count_d != '0);
      frame_err_d = (state_d == ERR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         data_out_q   <= '0;
         word_count_q <= '0;
         go_q         <= 1'b0;
         finish_q     <= 1'b0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_out_q   <= data_out_d;
         word_count_q <= word_count_d;
         go_q         <= go_d;
         finish_q     <= finish_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.word_count = word_count_q;
   assign bus.go         = go_q;
   assign bus.finish     = finish_q;
   assign bus.word_valid = word_valid_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_range_stream_framer.sv
// Bench for range_stream_framer: vector table of frames plus hand sequences, word scoreboard.
module tb_range_stream_framer;
   import range_pkg::*;

   localparam int W = 10;
   localparam int C = 8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic d_ser_in, d_ser_valid, d_fs, d_fe, sel;

   range_stream_framer_if #(.WIDTH(W), .CNT_W(C)) bus_a ();
   range_stream_framer_if #(.WIDTH(W), .CNT_W(C)) bus_b ();

   range_stream_framer #(.WIDTH(W), .MAX_WORDS(255), .CNT_W(C)) dut_a (
      .clock (clock), .reset (reset), .bus (bus_a.slave));
   range_stream_framer #(.WIDTH(W), .MAX_WORDS(2), .CNT_W(C)) dut_b (
      .clock (clock), .reset (reset), .bus (bus_b.slave));

   assign bus_a.ser_in      = d_ser_in    & ~sel;
   assign bus_a.ser_valid   = d_ser_valid & ~sel;
   assign bus_a.frame_start = d_fs        & ~sel;
   assign bus_a.frame_end   = d_fe        & ~sel;
   assign bus_b.ser_in      = d_ser_in    & sel;
   assign bus_b.ser_valid   = d_ser_valid & sel;
   assign bus_b.frame_start = d_fs        & sel;
   assign bus_b.frame_end   = d_fe        & sel;

   logic [W-1:0] m_data;
   logic [C-1:0] m_count;
   logic         m_go, m_finish, m_wv, m_err;
   assign m_data   = sel ? bus_b.data_out   : bus_a.data_out;
   assign m_count  = sel ? bus_b.word_count : bus_a.word_count;
   assign m_go     = sel ? bus_b.go         : bus_a.go;
   assign m_finish = sel ? bus_b.finish     : bus_a.finish;
   assign m_wv     = sel ? bus_b.word_valid : bus_a.word_valid;
   assign m_err    = sel ? bus_b.frame_err  : bus_a.frame_err;

   int n_cmp = 0;
   int n_bad = 0;
   int go_cnt, fin_cnt, wv_cnt;
   int rng_min, rng_max;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard on every word and tracks pulses and the value range
   always @(negedge clock) begin
      if (!reset) begin
         if (m_wv) begin
            wv_cnt++;
            if (exp_q.size() == 0) check("unexpected_word", int'(m_data), -1);
            else check("word_data", int'(m_data), int'(exp_q.pop_front()));
            if (m_go) begin
               rng_min = int'(m_data);
               rng_max = int'(m_data);
            end else begin
               if (int'(m_data) < rng_min) rng_min = int'(m_data);
               if (int'(m_data) > rng_max) rng_max = int'(m_data);
            end
         end
         if (m_go) begin
            go_cnt++;
            check("go_with_word", int'(m_wv), 1);
            check("go_not_finish", int'(m_finish), 0);
         end
         if (m_finish) fin_cnt++;
      end
   end

   task automatic cyc(input logic v, input logic b, input logic fs, input logic fe);
      d_ser_valid = v;
      d_ser_in    = b;
      d_fs        = fs;
      d_fe        = fe;
      @(posedge clock);
      #1;
      d_ser_valid = 1'b0;
      d_ser_in    = 1'b0;
      d_fs        = 1'b0;
      d_fe        = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit first, input bit end_last,
                            input bit gap, input bit push);
      for (int i = W - 1; i >= 0; i--) begin
         if (push && i == 0) exp_q.push_back(w);
         cyc(1'b1, w[i], first && i == W - 1, end_last && i == 0);
         if (gap && i != 0) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic clear_counts();
      go_cnt  = 0;
      fin_cnt = 0;
      wv_cnt  = 0;
   endtask

   typedef struct {
      int                  nwords;
      logic [2:0][W-1:0]   words;
      int                  partial;
      bit                  gap;
      bit                  exp_err;
      int                  exp_fin;
      int                  exp_range;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input int idx);
      vec_t v;
      logic [W-1:0] last_w;
      v = vecs[idx];
      last_w = v.words[v.nwords - 1];
      clear_counts();
      for (int k = 0; k < v.nwords; k++)
         send_word(v.words[k], k == 0, (k == v.nwords - 1) && v.partial == 0, v.gap, 1'b1);
      if (v.partial > 0) begin
         for (int j = 0; j < v.partial; j++) cyc(1'b1, j[0], 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
      end
      if (!v.exp_err) begin
         check($sformatf("v%0d_data_t1", idx), int'(m_data), int'(last_w));
         check($sformatf("v%0d_finish_t1", idx), int'(m_finish), 0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("v%0d_finish_t2", idx), int'(m_finish), 1);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("v%0d_finish_t3", idx), int'(m_finish), 0);
      end
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_frame_err", idx), int'(m_err), int'(v.exp_err));
      check($sformatf("v%0d_word_count", idx), int'(m_count), v.nwords);
      check($sformatf("v%0d_data_out", idx), int'(m_data), int'(last_w));
      check($sformatf("v%0d_go_count", idx), go_cnt, 1);
      check($sformatf("v%0d_finish_count", idx), fin_cnt, v.exp_fin);
      check($sformatf("v%0d_word_pulses", idx), wv_cnt, v.nwords);
      if (!v.exp_err) check($sformatf("v%0d_range", idx), rng_max - rng_min, v.exp_range);
   endtask

   initial begin
      vecs[0] = '{nwords: 3, words: {10'h100, 10'h3FF, 10'h005}, partial: 0, gap: 0,
                  exp_err: 0, exp_fin: 1, exp_range: 'h3FA};
      vecs[1] = '{nwords: 1, words: {10'h000, 10'h000, 10'h2AA}, partial: 0, gap: 1,
                  exp_err: 0, exp_fin: 1, exp_range: 0};
      vecs[2] = '{nwords: 1, words: {10'h000, 10'h000, 10'h011}, partial: 4, gap: 0,
                  exp_err: 1, exp_fin: 1, exp_range: 0};
      vecs[3] = '{nwords: 2, words: {10'h000, 10'h3FF, 10'h000}, partial: 0, gap: 0,
                  exp_err: 0, exp_fin: 1, exp_range: 'h3FF};
      vecs[4] = '{nwords: 3, words: {10'h3C3, 10'h200, 10'h1FF}, partial: 0, gap: 0,
                  exp_err: 0, exp_fin: 1, exp_range: 'h1C4};

      sel = 1'b0;
      d_ser_in = 1'b0; d_ser_valid = 1'b0; d_fs = 1'b0; d_fe = 1'b0;
      clear_counts();
      rng_min = 0; rng_max = 0;
      reset = 1'b1;
      #3;
      check("rst_data_out", int'(bus_a.data_out), 0);
      check("rst_go", int'(bus_a.go), 0);
      check("rst_finish", int'(bus_a.finish), 0);
      check("rst_word_valid", int'(bus_a.word_valid), 0);
      check("rst_word_count", int'(bus_a.word_count), 0);
      check("rst_frame_err", int'(bus_a.frame_err), 0);
      #9 reset = 1'b0;
      @(posedge clock); #1;

      // stray serial bits in IDLE must be ignored
      clear_counts();
      repeat (12) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check("idle_ignore_pulses", wv_cnt, 0);

      for (int i = 0; i < 5; i++) run_vec(i);

      // empty frame: start and end together
      clear_counts();
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      check("empty_frame_err", int'(m_err), 1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("empty_go", go_cnt, 0);
      check("empty_finish", fin_cnt, 0);
      check("empty_word_valid", wv_cnt, 0);
      check("empty_word_count", int'(m_count), 0);
      check("empty_err_held", int'(m_err), 1);

      // asynchronous reset part-way through the second word
      clear_counts();
      send_word(10'h155, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 5; j++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("mrst_data_out", int'(bus_a.data_out), 0);
      check("mrst_word_count", int'(bus_a.word_count), 0);
      check("mrst_go", int'(bus_a.go), 0);
      check("mrst_finish", int'(bus_a.finish), 0);
      check("mrst_word_valid", int'(bus_a.word_valid), 0);
      check("mrst_frame_err", int'(bus_a.frame_err), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("mrst_no_finish", fin_cnt, 0);
      run_vec(0);

      // overflow on the MAX_WORDS=2 instance
      sel = 1'b1;
      #1;
      clear_counts();
      send_word(10'h001, 1'b1, 1'b0, 1'b0, 1'b1);
      send_word(10'h002, 1'b0, 1'b0, 1'b0, 1'b1);
      send_word(10'h003, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovf_frame_err", int'(m_err), 1);
      check("ovf_data_out", int'(m_data), 'h002);
      check("ovf_word_count", int'(m_count), 2);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("ovf_finish_count", fin_cnt, 1);
      check("ovf_go_count", go_cnt, 1);
      check("ovf_word_pulses", wv_cnt, 2);
      check("ovf_err_held", int'(m_err), 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      check("ovf_restart_err", int'(m_err), 0);
      check("ovf_restart_count", int'(m_count), 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/range_stream_framer.md
Name: range_stream_framer

Overview:
- Upstream feeder for the range-finder stage. Deserializes a framed, MSB-first serial sample stream into WIDTH-bit words.
- Drives the range finder's data/go/finish inputs with the timing that stage needs:
  - go coincides with the first word.
  - Each word is held stable until the next word replaces it.
  - finish arrives only after the last word has been visible for at least one cycle.
- Also flags framing errors and forces the downstream stage out of its reading state when a frame is aborted.

Parameters:
- WIDTH, 10, bits per sample word; equals the range finder data width.
- MAX_WORDS, 255, maximum words per frame; completing word MAX_WORDS+1 is an overflow error.
- CNT_W, 8, width of word_count; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ser_in  in  1  serial data bit.
- ser_valid  in  1  ser_in is sampled this cycle.
- frame_start  in  1  single-cycle frame-open marker.
- frame_end  in  1  single-cycle frame-close marker.
- data_out  out  WIDTH  last completed word; connects to range finder data input.
- go  out  1  one-cycle pulse; first word of frame is on data_out.
- finish  out  1  one-cycle frame-close pulse to the range finder.
- word_valid  out  1  one-cycle pulse per completed word.
- word_count  out  CNT_W  words completed in current/last frame.
- frame_err  out  1  high while in ERR state.

Behaviour:
- All outputs are registered. Reset values: data_out=0, go=0, finish=0, word_valid=0, word_count=0, frame_err=0, state=IDLE, bit counter=0.
- States: IDLE, SHIFT, DRAIN, FIN, ERR.
- IDLE:
  - ser_valid without frame_start is ignored.
  - frame_start alone -> SHIFT. Bit and word counters clear; a ser_valid bit in the same cycle is accepted as bit 0.
  - frame_start and frame_end in the same cycle -> ERR (empty frame). No go, no finish.
- SHIFT, per ser_valid:
  - shift register <= {shift[WIDTH-2:0], ser_in}; bit counter increments.
  - When the bit counter completes WIDTH bits, on that edge:
    - data_out <= assembled word, word_valid=1 next cycle, word_count+1, bit counter wraps to 0.
    - go=1 next cycle only if this is word 1.
  - ser_valid low: no change.
- SHIFT, frame_end (evaluated against the post-update bit counter, so frame_end may coincide with the last bit):
  - Aligned (bit counter 0) with word_count>=1 -> DRAIN.
  - Partial word, or zero words -> ERR.
- Latency: last bit at cycle t -> data_out new at t+1 (DRAIN) -> finish=1 at t+2 (FIN) -> IDLE at t+3.
- FIN:
  - finish=1 for exactly one cycle.
  - Next state IDLE; frame_start in FIN -> SHIFT.
- Protocol errors: frame_start while in SHIFT or DRAIN -> ERR.
- Overflow: a word completing with word_count==MAX_WORDS -> ERR. Word discarded; data_out and word_count unchanged.
- ERR:
  - frame_err=1 throughout.
  - On entry, finish pulses one cycle iff word_count>=1, releasing the downstream reading state. go is never asserted.
  - Remains in ERR until frame_start -> SHIFT, which clears frame_err and the counters.
  - frame_end and ser_valid are ignored in ERR.
- word_count holds its last value in IDLE/FIN/ERR and clears on frame_start.
- data_out holds its last value across frames.
- go and finish are never high in the same cycle.
- Asynchronous reset mid-frame returns to IDLE with reset values. No finish is emitted.

Decomposition:
- Package range_pkg:
  - WIDTH default constant, shared with the range finder.
  - typedef framer_state_t enum {IDLE, SHIFT, DRAIN, FIN, ERR}.
- Sub-module bit_deserializer: shift register plus bit counter, with ports clock, reset, clear, ser_in, ser_valid, word, word_done. The FSM and output registers stay in range_stream_framer.

Test Plan (WIDTH=10 unless noted):
- Nominal frame: start, words 0x005, 0x3FF, 0x100 back-to-back, frame_end on last bit (cycle t) -> go with data_out=0x005; three word_valid pulses; data_out=0x100 at t+1; finish at t+2 only; word_count=3. Chained range finder outputs 0x3FA.
- Gapped serial: 0x2AA sent with ser_valid low on alternate cycles -> data_out=0x2AA, go once. Bit-timing gaps do not alter the word.
- Partial frame_end: one full word 0x011, then 4 bits, then frame_end -> frame_err=1, finish pulse one cycle, word_count=1. Next frame_start clears frame_err.
- Empty frame: frame_start and frame_end in the same cycle in IDLE -> frame_err=1; go, finish and word_valid all stay 0.
- Overflow (MAX_WORDS=2): three words 0x001, 0x002, 0x003 -> ERR on third completion; data_out stays 0x002, word_count=2, finish pulses once.
- Reset mid-frame: assert reset after 5 bits of word 2 -> all outputs 0, state IDLE immediately, no finish. A following clean frame behaves as in the nominal case.
